// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART datapath (RX now, TX later).
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_DATA     = 3'd2,
        ST_PAR      = 3'd3,
        ST_STOP     = 3'd4,
        ST_BRK_WAIT = 3'd5
    } rx_state_e;

    // A receive word carries {perr, ferr, data}.
    localparam int RX_FLAG_BITS = 2;

    function automatic int os_div(input int clk_frq, input int baud, input int os);
        return clk_frq / (baud * os);
    endfunction

    function automatic int rx_word_w(input int data_bits);
        return data_bits + RX_FLAG_BITS;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through FIFO with full/empty; the head word reads as 0 when empty.
module uart_sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, rd_q;
    logic             wr_en, rd_en;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign rd_en   = pop_i && !empty_o;
    // A pop on the same clk frees the slot the push needs when full.
    assign wr_en   = push_i && (!full_o || rd_en);
    assign rdata_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (wr_en) wr_q <= wr_q + 1'b1;
            if (rd_en) rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: line synchroniser, free-running tick generator,
// frame FSM and a FWFT receive FIFO behind a valid/ready handshake.
//
// state       | meaning
// ST_IDLE     | line idle, waiting for a low level on a tick
// ST_START    | confirming the start bit at its centre
// ST_DATA     | shifting data bits LSB-first at bit centre
// ST_PAR      | sampling the parity bit
// ST_STOP     | sampling stop bit(s); pushes the word on the last one
// ST_BRK_WAIT | last stop bit was low, waiting for the line to return high
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int CLK_FRQ    = 250000000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 areset,
    input  logic                 rx_in,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_perr,
    output logic                 rx_ferr,
    output logic                 overrun,
    output logic                 rx_busy
);

    localparam int OS_DIV  = os_div(CLK_FRQ, BAUD_RATE, OVERSAMPLE);
    localparam int DIV_W   = (OS_DIV > 2) ? $clog2(OS_DIV) : 1;
    localparam int PH_W    = $clog2(OVERSAMPLE);
    localparam int BC_W    = 4;
    localparam int WORD_W  = rx_word_w(DATA_BITS);
    localparam parity_e PAR_MODE = parity_e'(PARITY);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(OS_DIV - 1);
    localparam logic [PH_W-1:0]  PH_MID    = PH_W'(OVERSAMPLE / 2 - 1);
    localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(OVERSAMPLE - 1);
    localparam logic [BC_W-1:0]  DATA_LAST = BC_W'(DATA_BITS - 1);
    localparam logic [BC_W-1:0]  STOP_LAST = BC_W'(STOP_BITS - 1);
    localparam logic             PAR_EXP   = (PAR_MODE == PAR_ODD);

    generate
        if (OS_DIV < 2) begin : g_bad_div
            $error("uart_rx_os: CLK_FRQ/(BAUD_RATE*OVERSAMPLE) must be at least 2");
        end
    endgenerate

    logic [1:0]           sync_q;
    logic                 rx_s;
    logic [DIV_W-1:0]     div_q, div_d;
    logic                 tick;
    rx_state_e            state_q, state_d;
    logic [PH_W-1:0]      phase_q, phase_d;
    logic [BC_W-1:0]      bit_q, bit_d;
    logic [DATA_BITS-1:0] data_q;
    logic                 perr_q, ferr_q, overrun_q;
    logic                 mid_smp, ctr_smp;
    logic                 shift_en, par_en, stop_en, push, busy;
    logic [WORD_W-1:0]    push_word, head_word;
    logic                 fifo_full, fifo_empty, pop;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            sync_q <= 2'b11;
            div_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], rx_in};
            div_q  <= div_d;
        end
    end

    assign rx_s    = sync_q[1];
    assign tick    = (div_q == DIV_LAST);
    assign div_d   = tick ? '0 : div_q + 1'b1;
    assign mid_smp = tick && (phase_q == PH_MID);
    assign ctr_smp = tick && (phase_q == PH_LAST);

    always_ff @(posedge clk or posedge areset) begin
        if (areset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (tick && !rx_s) state_d = ST_START;
            ST_START:    if (mid_smp) state_d = rx_s ? ST_IDLE : ST_DATA;
            ST_DATA:     if (ctr_smp && (bit_q == DATA_LAST))
                             state_d = (PAR_MODE != PAR_NONE) ? ST_PAR : ST_STOP;
            ST_PAR:      if (ctr_smp) state_d = ST_STOP;
            ST_STOP:     if (ctr_smp && (bit_q == STOP_LAST))
                             state_d = rx_s ? ST_IDLE : ST_BRK_WAIT;
            ST_BRK_WAIT: if (tick && rx_s) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        shift_en = 1'b0;
        par_en   = 1'b0;
        stop_en  = 1'b0;
        push     = 1'b0;
        busy     = 1'b0;
        case (state_q)
            ST_START: busy = 1'b1;
            ST_DATA: begin
                busy     = 1'b1;
                shift_en = ctr_smp;
            end
            ST_PAR: begin
                busy   = 1'b1;
                par_en = ctr_smp;
            end
            ST_STOP: begin
                busy    = 1'b1;
                stop_en = ctr_smp;
                push    = ctr_smp && (bit_q == STOP_LAST);
            end
            default: ;
        endcase
    end

    // Phase and bit counters restart on every state change so each state
    // measures its sample points from its own entry.
    always_comb begin
        phase_d = phase_q;
        bit_d   = bit_q;
        if (state_d != state_q) begin
            phase_d = '0;
            bit_d   = '0;
        end else if (tick) begin
            phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
            if (phase_q == PH_LAST) bit_d = bit_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            phase_q   <= '0;
            bit_q     <= '0;
            data_q    <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            bit_q   <= bit_d;
            if (state_q == ST_IDLE && state_d == ST_START) begin
                perr_q <= 1'b0;
                ferr_q <= 1'b0;
            end
            if (shift_en) data_q <= {rx_s, data_q[DATA_BITS-1:1]};
            if (par_en) perr_q <= (^data_q ^ rx_s) != PAR_EXP;
            if (stop_en && !rx_s) ferr_q <= 1'b1;
            overrun_q <= push && fifo_full && !pop;
        end
    end

    // The last stop sample is folded in directly since the push happens on that clk.
    assign push_word = {perr_q, ferr_q | ~rx_s, data_q};
    assign pop       = rx_ready && !fifo_empty;

    uart_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .areset  (areset),
        .push_i  (push),
        .wdata_i (push_word),
        .pop_i   (pop),
        .rdata_o (head_word),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign rx_valid                  = !fifo_empty;
    assign {rx_perr, rx_ferr, rx_data} = head_word;
    assign overrun                   = overrun_q;
    assign rx_busy                   = busy;

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: three instances (8N1, 7E1, 8N2) driven with framed
// serial traffic and checked against a queue-based frame model.
`timescale 1ns/1ps
module tb_uart_rx_os;

    localparam int CLK_FRQ = 3686400;
    localparam int BAUD    = 115200;
    localparam int OS      = 16;
    localparam int BIT_CLK = 32;
    localparam int DEPTH   = 4;

    typedef struct packed {
        logic [8:0] d;
        logic       p;
        logic       f;
    } exp_t;

    logic       clk     = 1'b0;
    logic       areset  = 1'b1;
    logic [2:0] rx_line = 3'b111;
    logic [2:0] rdy     = 3'b111;

    logic       vld0, perr0, ferr0, ovr0, busy0;
    logic       vld1, perr1, ferr1, ovr1, busy1;
    logic       vld2, perr2, ferr2, ovr2, busy2;
    logic [7:0] d0, d2;
    logic [6:0] d1;

    exp_t q0[$], q1[$], q2[$];
    exp_t e0, e1, e2;
    int   exp_ovr [3] = '{0, 0, 0};
    int   got_ovr [3] = '{0, 0, 0};
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    uart_rx_os #(.CLK_FRQ(CLK_FRQ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8),
                 .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_8n1 (
        .clk(clk), .areset(areset), .rx_in(rx_line[0]), .rx_valid(vld0), .rx_ready(rdy[0]),
        .rx_data(d0), .rx_perr(perr0), .rx_ferr(ferr0), .overrun(ovr0), .rx_busy(busy0));

    uart_rx_os #(.CLK_FRQ(CLK_FRQ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS), .DATA_BITS(7),
                 .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_7e1 (
        .clk(clk), .areset(areset), .rx_in(rx_line[1]), .rx_valid(vld1), .rx_ready(rdy[1]),
        .rx_data(d1), .rx_perr(perr1), .rx_ferr(ferr1), .overrun(ovr1), .rx_busy(busy1));

    uart_rx_os #(.CLK_FRQ(CLK_FRQ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8),
                 .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u_8n2 (
        .clk(clk), .areset(areset), .rx_in(rx_line[2]), .rx_valid(vld2), .rx_ready(rdy[2]),
        .rx_data(d2), .rx_perr(perr2), .rx_ferr(ferr2), .overrun(ovr2), .rx_busy(busy2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Every accepted head word must match the oldest frame the model expects.
    always @(negedge clk) begin
        if (!areset && vld0 && rdy[0]) begin
            if (q0.size() == 0) chk("u8n1_unexpected_word", 32'(d0), 32'hFFFF_FFFF);
            else begin
                e0 = q0.pop_front();
                chk("u8n1_data", 32'(d0), 32'(e0.d[7:0]));
                chk("u8n1_perr", 32'(perr0), 32'(e0.p));
                chk("u8n1_ferr", 32'(ferr0), 32'(e0.f));
            end
        end
        if (ovr0) got_ovr[0]++;
    end

    always @(negedge clk) begin
        if (!areset && vld1 && rdy[1]) begin
            if (q1.size() == 0) chk("u7e1_unexpected_word", 32'(d1), 32'hFFFF_FFFF);
            else begin
                e1 = q1.pop_front();
                chk("u7e1_data", 32'(d1), 32'(e1.d[6:0]));
                chk("u7e1_perr", 32'(perr1), 32'(e1.p));
                chk("u7e1_ferr", 32'(ferr1), 32'(e1.f));
            end
        end
        if (ovr1) got_ovr[1]++;
    end

    always @(negedge clk) begin
        if (!areset && vld2 && rdy[2]) begin
            if (q2.size() == 0) chk("u8n2_unexpected_word", 32'(d2), 32'hFFFF_FFFF);
            else begin
                e2 = q2.pop_front();
                chk("u8n2_data", 32'(d2), 32'(e2.d[7:0]));
                chk("u8n2_perr", 32'(perr2), 32'(e2.p));
                chk("u8n2_ferr", 32'(ferr2), 32'(e2.f));
            end
        end
        if (ovr2) got_ovr[2]++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Model the frame (only instance 1 has parity, even), then drive it on line w.
    task automatic xmit(input int w, input logic [8:0] data, input int nbits, input bit haspar,
                        input logic pbit, input int nstop, input logic [1:0] stops);
        exp_t e;
        int   ones;
        logic [8:0] mask;
        mask = 9'((1 << nbits) - 1);
        ones = $countones(data & mask);
        e.d  = data & mask;
        e.p  = haspar && (((ones + int'(pbit)) % 2) == 1);
        e.f  = !stops[0] || (nstop == 2 && !stops[1]);
        case (w)
            0: if (q0.size() >= DEPTH) exp_ovr[0]++; else q0.push_back(e);
            1: if (q1.size() >= DEPTH) exp_ovr[1]++; else q1.push_back(e);
            default: if (q2.size() >= DEPTH) exp_ovr[2]++; else q2.push_back(e);
        endcase
        rx_line[w] = 1'b0;
        step(BIT_CLK);
        for (int i = 0; i < nbits; i++) begin
            rx_line[w] = data[i];
            step(BIT_CLK);
        end
        if (haspar) begin
            rx_line[w] = pbit;
            step(BIT_CLK);
        end
        for (int i = 0; i < nstop; i++) begin
            rx_line[w] = stops[i];
            step(BIT_CLK);
        end
    endtask

    task automatic wait_drain(input int w, input int budget);
        int left;
        left = 0;
        for (int i = 0; i < budget; i++) begin
            left = (w == 0) ? q0.size() : (w == 1) ? q1.size() : q2.size();
            if (left == 0) break;
            step(1);
        end
        chk($sformatf("drain_line%0d", w), 32'(left), 32'd0);
    endtask

    initial begin
        logic [1:0] st;
        logic       seen;

        step(3);
        chk("rst_valid", {29'd0, vld2, vld1, vld0}, 32'd0);
        chk("rst_data", {8'd0, d2, 1'b0, d1, d0}, 32'd0);
        chk("rst_flags", {26'd0, perr0, ferr0, perr1, ferr1, perr2, ferr2}, 32'd0);
        chk("rst_ovr_busy", {26'd0, ovr0, ovr1, ovr2, busy0, busy1, busy2}, 32'd0);
        areset = 1'b0;
        step(20);

        xmit(0, 9'h0A5, 8, 1'b0, 1'b0, 1, 2'b11);
        wait_drain(0, 200);
        step(2);
        chk("a5_valid_after", 32'(vld0), 32'd0);

        xmit(1, 9'h055, 7, 1'b1, 1'b0, 1, 2'b11);
        xmit(1, 9'h055, 7, 1'b1, 1'b1, 1, 2'b11);
        wait_drain(1, 200);

        // Second stop low, then the line is held low as a break.
        xmit(2, 9'h03C, 8, 1'b0, 1'b0, 2, 2'b01);
        seen = 1'b0;
        for (int i = 0; i < 3 * BIT_CLK; i++) begin
            step(1);
            seen = seen | busy2;
        end
        chk("brk_no_restart", 32'(seen), 32'd0);
        wait_drain(2, 50);
        rx_line[2] = 1'b1;
        step(2 * BIT_CLK);

        rx_line[0] = 1'b0;
        step(6);
        rx_line[0] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step(1);
            seen = seen | busy0;
        end
        chk("glitch_busy_pulse", 32'(seen), 32'd1);
        chk("glitch_busy_end", 32'(busy0), 32'd0);
        chk("glitch_no_push", 32'(vld0), 32'd0);

        for (int k = 0; k < 12; k++) begin
            st = {1'b1, 1'($urandom_range(0, 5) != 0)};
            xmit(0, 9'($urandom_range(0, 255)), 8, 1'b0, 1'b0, 1, st);
            rx_line[0] = 1'b1;
            if (!st[0]) step(BIT_CLK);
            step($urandom_range(0, 20));
        end
        wait_drain(0, 200);

        for (int k = 0; k < 8; k++) begin
            xmit(1, 9'($urandom_range(0, 127)), 7, 1'b1, 1'($urandom_range(0, 1)), 1, 2'b11);
            step($urandom_range(0, 10));
        end
        wait_drain(1, 200);

        for (int k = 0; k < 8; k++) begin
            st = {1'b1, 1'($urandom_range(0, 3) != 0)};
            xmit(2, 9'($urandom_range(0, 255)), 8, 1'b0, 1'b0, 2, st);
            step($urandom_range(0, 10));
        end
        wait_drain(2, 200);

        rdy[0] = 1'b0;
        for (int k = 1; k <= 5; k++) xmit(0, 9'(k), 8, 1'b0, 1'b0, 1, 2'b11);
        step(40);
        chk("ovr_pulse_count", 32'(got_ovr[0]), 32'(exp_ovr[0]));
        chk("ovr_full_valid", 32'(vld0), 32'd1);
        rdy[0] = 1'b1;
        wait_drain(0, 100);
        step(4);
        chk("ovr_drained_valid", 32'(vld0), 32'd0);

        rdy[0] = 1'b0;
        xmit(0, 9'($urandom_range(0, 255)), 8, 1'b0, 1'b0, 1, 2'b11);
        xmit(0, 9'($urandom_range(0, 255)), 8, 1'b0, 1'b0, 1, 2'b11);
        step(10);
        chk("midrst_queued", 32'(vld0), 32'd1);
        rx_line[0] = 1'b0;
        step(BIT_CLK);
        for (int i = 0; i < 3; i++) begin
            rx_line[0] = 1'(i % 2 == 0);
            step(BIT_CLK);
        end
        areset = 1'b1;
        step(2);
        chk("midrst_outputs", {25'd0, vld0, perr0, ferr0, ovr0, busy0, 2'b00}, 32'd0);
        chk("midrst_data", 32'(d0), 32'd0);
        q0.delete();
        rx_line[0] = 1'b1;
        step(3);
        areset = 1'b0;
        step(40);
        rdy[0] = 1'b1;
        step(2);
        chk("postrst_empty", 32'(vld0), 32'd0);
        xmit(0, 9'h0FF, 8, 1'b0, 1'b0, 1, 2'b11);
        wait_drain(0, 200);
        step(4);
        chk("postrst_valid_after", 32'(vld0), 32'd0);

        chk("ovr_total_8n1", 32'(got_ovr[0]), 32'(exp_ovr[0]));
        chk("ovr_total_7e1", 32'(got_ovr[1]), 32'(exp_ovr[1]));
        chk("ovr_total_8n2", 32'(got_ovr[2]), 32'(exp_ovr[2]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
